motor_pwm_ramp: RTL

//  Motor speed stage downstream of the clock divider. Consumes its one-clk `tick` pulse as the ramp-step enable.

---
 rtl/motor_defs.sv | 16 +
 rtl/pwm_gen.sv | 50 +++++
 rtl/motor_pwm_ramp.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/motor_defs.sv
// Shared definitions for the motor speed stage: FSM state encodings and
// default sizing for the PWM/ramp datapath.
package motor_defs;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAMP     = 2'd1,
        RUN      = 2'd2,
        REV_WAIT = 2'd3
    } state_t;

    localparam int DEF_PWM_WIDTH  = 8;
    localparam int DEF_STEP       = 4;
    localparam int DEF_DEAD_TICKS = 2;

endpackage

// File: rtl/pwm_gen.sv
// PWM generator: free-running counter, duty latched only at the period
// boundary so a duty change never produces a runt pulse, registered compare.
// clr forces the latched duty and the output low on the next edge.
module pwm_gen
    import motor_defs::*;
#(
    parameter int PWM_WIDTH = DEF_PWM_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic [PWM_WIDTH-1:0] duty,
    output logic                 pwm
);

    logic [PWM_WIDTH-1:0] cnt_p0;
    logic [PWM_WIDTH-1:0] duty_p0;

    // Free-running period counter, wraps all-ones -> 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p0 <= '0;
        end else begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end
    end

    // Duty latch: reload at the last count of a period, clear at once on clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_p0 <= '0;
        end else if (clr) begin
            duty_p0 <= '0;
        end else if (&cnt_p0) begin
            duty_p0 <= duty;
        end
    end

    // Registered compare; high for exactly duty_p0 counts of each period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm <= 1'b0;
        end else if (clr) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt_p0 < duty_p0);
        end
    end

endmodule

// File: rtl/motor_pwm_ramp.sv
// Motor speed stage: accepts speed/direction commands, soft-starts and
// soft-stops the duty by STEP per tick, reverses through zero with a dead
// time before flipping direction, and drives an H-bridge PWM/dir pair.
module motor_pwm_ramp
    import motor_defs::*;
#(
    parameter int PWM_WIDTH  = DEF_PWM_WIDTH,
    parameter int STEP       = DEF_STEP,
    parameter int DEAD_TICKS = DEF_DEAD_TICKS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 estop,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [PWM_WIDTH-1:0] cmd_duty,
    input  logic                 cmd_dir,
    output logic                 pwm_out,
    output logic                 dir_out,
    output logic [PWM_WIDTH-1:0] cur_duty,
    output logic                 at_target
);

    localparam logic signed [PWM_WIDTH+1:0] STEP_S    = (PWM_WIDTH+2)'(STEP);
    localparam logic        [7:0]           DEAD_LAST = 8'(DEAD_TICKS - 1);

    // One ramp step toward tgt, clamped so it never overshoots or wraps.
    function automatic logic [PWM_WIDTH-1:0] ramp_step(
        input logic [PWM_WIDTH-1:0] cur,
        input logic [PWM_WIDTH-1:0] tgt
    );
        logic signed [PWM_WIDTH+1:0] c;
        logic signed [PWM_WIDTH+1:0] t;
        logic signed [PWM_WIDTH+1:0] s;
        c = signed'({2'b00, cur});
        t = signed'({2'b00, tgt});
        if (c < t) begin
            s = c + STEP_S;
            if (s > t) s = t;
        end else begin
            s = c - STEP_S;
            if (s < t) s = t;
        end
        return s[PWM_WIDTH-1:0];
    endfunction

    state_t               state, state_nxt;
    logic [PWM_WIDTH-1:0] tgt_duty, tgt_duty_nxt;
    logic                 tgt_dir, tgt_dir_nxt;
    logic [PWM_WIDTH-1:0] cur_nxt;
    logic                 dir_nxt;
    logic [7:0]           dead_cnt, dead_nxt;
    logic [PWM_WIDTH-1:0] eff_tgt;
    logic [PWM_WIDTH-1:0] step_val;
    logic                 accept;

    assign at_target = (state == IDLE) || (state == RUN);
    assign cmd_ready = at_target && !estop;
    assign accept    = cmd_valid && cmd_ready;
    // A pending reversal ramps to zero first.
    assign eff_tgt   = (tgt_dir != dir_out) ? '0 : tgt_duty;
    assign step_val  = ramp_step(cur_duty, eff_tgt);

    // State and ramp registers; estop handling lives in the next-state logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_duty <= '0;
            tgt_duty <= '0;
            tgt_dir  <= 1'b0;
            dir_out  <= 1'b0;
            dead_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cur_duty <= cur_nxt;
            tgt_duty <= tgt_duty_nxt;
            tgt_dir  <= tgt_dir_nxt;
            dir_out  <= dir_nxt;
            dead_cnt <= dead_nxt;
        end
    end

    // Next-state, ramp stepping and dead-time counting.
    always_comb begin
        state_nxt    = state;
        cur_nxt      = cur_duty;
        tgt_duty_nxt = tgt_duty;
        tgt_dir_nxt  = tgt_dir;
        dir_nxt      = dir_out;
        dead_nxt     = dead_cnt;
        if (estop) begin
            state_nxt    = IDLE;
            cur_nxt      = '0;
            tgt_duty_nxt = '0;
            dead_nxt     = '0;
        end else begin
            if (accept) begin
                tgt_duty_nxt = cmd_duty;
                tgt_dir_nxt  = cmd_dir;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_dir != dir_out) begin
                            state_nxt = REV_WAIT;
                        end else if (cmd_duty != '0) begin
                            state_nxt = RAMP;
                        end
                    end
                end
                RUN: begin
                    if (accept && ((cmd_dir != dir_out) || (cmd_duty != cur_duty))) begin
                        state_nxt = RAMP;
                    end
                end
                RAMP: begin
                    if (tick) begin
                        cur_nxt = step_val;
                        if (step_val == eff_tgt) begin
                            if (eff_tgt == '0 && tgt_dir != dir_out) begin
                                state_nxt = REV_WAIT;
                                dead_nxt  = '0;
                            end else if (eff_tgt == '0) begin
                                state_nxt = IDLE;
                            end else begin
                                state_nxt = RUN;
                            end
                        end
                    end
                end
                REV_WAIT: begin
                    if (tick) begin
                        if (dead_cnt == DEAD_LAST) begin
                            dead_nxt  = '0;
                            dir_nxt   = tgt_dir;
                            state_nxt = (tgt_duty != '0) ? RAMP : IDLE;
                        end else begin
                            dead_nxt = dead_cnt + 8'd1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---- ramped duty -> PWM stage ----
    pwm_gen #(
        .PWM_WIDTH(PWM_WIDTH)
    ) u_pwm_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (estop),
        .duty   (cur_duty),
        .pwm    (pwm_out)
    );

endmodule
